mant_mult_pipe: RTL and testbench



---
 rtl/mant_mult_pkg.sv | 24 ++
 rtl/mant_mult_if.sv | 39 +++
 rtl/mant_round_ne.sv | 39 +++
 rtl/mant_mult_pipe.sv | 104 ++++++++++
 tb/tb_mant_mult_pipe.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mant_mult_pkg.sv
// Shared types and limits for the pipelined mantissa multiplier.
// Optional round stage is enabled by defining MANT_MULT_ROUND_EN.
package mant_mult_pkg;

    localparam int W_MIN      = 8;
    localparam int W_MAX      = 64;
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 6;
    localparam int TAG_W_MIN  = 1;
    localparam int TAG_W_MAX  = 16;
    localparam int P_W_MAX    = 2 * W_MAX;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Sized for the widest legal build; narrower builds use the low bits.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [P_W_MAX-1:0]   prod;
    } stage_t;

endpackage

// File: rtl/mant_mult_if.sv
// Handshake bundle between operand unpack, multiplier and exponent adjust.
// M and EXP_INC exist only when MANT_MULT_ROUND_EN is defined.
interface mant_mult_if #(
    parameter int W     = 24,
    parameter int TAG_W = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [W:0]       R;
    logic             STICKY;
    logic [TAG_W-1:0] OUT_TAG;
`ifdef MANT_MULT_ROUND_EN
    logic [W-1:0]     M;
    logic             EXP_INC;

    modport master (
        output IN_VALID, A, B, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, R, STICKY, OUT_TAG, M, EXP_INC
    );
    modport slave (
        input  IN_VALID, A, B, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, R, STICKY, OUT_TAG, M, EXP_INC
    );
`else
    modport master (
        output IN_VALID, A, B, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, R, STICKY, OUT_TAG
    );
    modport slave (
        input  IN_VALID, A, B, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, R, STICKY, OUT_TAG
    );
`endif
endinterface

// File: rtl/mant_round_ne.sv
// Normalise a 2W-bit product and round to nearest even.
// Present only when MANT_MULT_ROUND_EN is defined.
`ifdef MANT_MULT_ROUND_EN
module mant_round_ne #(
    parameter int W = 24
) (
    input  logic [2*W-1:0] p,
    output logic [W-1:0]   m,
    output logic           exp_inc
);
    logic         top;
    logic [W-1:0] mant;
    logic         guard;
    logic         sticky;
    logic         rup;
    logic [W:0]   sum;

    always_comb begin
        top     = p[2*W-1];
        mant    = p[2*W-2:W-1];
        guard   = p[W-2];
        sticky  = |p[W-3:0];
        if (top) begin
            mant   = p[2*W-1:W];
            guard  = p[W-1];
            sticky = |p[W-2:0];
        end
        rup = guard & (sticky | mant[0]);
        sum = {1'b0, mant} + {{W{1'b0}}, rup};
        m       = sum[W-1:0];
        exp_inc = top;
        // All-ones mantissa rounding up wraps to 1.000...
        if (sum[W]) begin
            m       = {1'b1, {(W-1){1'b0}}};
            exp_inc = 1'b1;
        end
    end
endmodule
`endif

// File: rtl/mant_mult_pipe.sv
// Pipelined unsigned mantissa multiplier with valid/ready and tag sideband.
// Define MANT_MULT_ROUND_EN to add the round-to-nearest-even output stage.
module mant_mult_pipe
    import mant_mult_pkg::*;
#(
    parameter int W      = 24,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic       CLK,
    input logic       RESET,
    mant_mult_if.slave bus
);
    localparam int PW = prod_w(W);
    localparam int H  = W / 2;
    localparam int HW = W - H;

    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("mant_mult_pipe: W out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_s
        $error("mant_mult_pipe: STAGES out of range");
    end
    if (TAG_W < TAG_W_MIN || TAG_W > TAG_W_MAX) begin : g_bad_t
        $error("mant_mult_pipe: TAG_W out of range");
    end

    stage_t           pipe [STAGES];
    logic [W+HW-1:0]  hi_q;
    logic [W+H-1:0]   pp_lo;
    logic [W+HW-1:0]  pp_hi;
    logic [PW-1:0]    sum;
    stage_t           out_s;
    logic             en;
    logic             unused_pad;

    assign en           = bus.OUT_READY | ~out_s.valid;
    assign bus.IN_READY = en;

    // Stage 0 forms two half-width partial products; stage 1 sums them.
    assign pp_lo = {{H{1'b0}}, bus.A} * {{W{1'b0}}, bus.B[H-1:0]};
    assign pp_hi = {{HW{1'b0}}, bus.A} * {{W{1'b0}}, bus.B[W-1:H]};
    assign sum   = PW'(pipe[0].prod[W+H-1:0]) + (PW'(hi_q) << H);

    always_ff @(posedge CLK) begin
        if (en) begin
            pipe[0].valid <= bus.IN_VALID;
            pipe[0].tag   <= TAG_W_MAX'(bus.IN_TAG);
            pipe[0].prod  <= P_W_MAX'(pp_lo);
            hi_q          <= pp_hi;
            pipe[1]       <= '{valid: pipe[0].valid,
                               tag:   pipe[0].tag,
                               prod:  P_W_MAX'(sum)};
            for (int i = 2; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
        if (RESET) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i].valid <= 1'b0;
            end
        end
    end

`ifdef MANT_MULT_ROUND_EN
    stage_t       rnd_q;
    logic [W-1:0] m_q;
    logic         inc_q;
    logic [W-1:0] m_d;
    logic         inc_d;

    mant_round_ne #(.W(W)) u_round (
        .p       (pipe[STAGES-1].prod[PW-1:0]),
        .m       (m_d),
        .exp_inc (inc_d)
    );

    always_ff @(posedge CLK) begin
        if (en) begin
            rnd_q <= pipe[STAGES-1];
            m_q   <= m_d;
            inc_q <= inc_d;
        end
        if (RESET) begin
            rnd_q.valid <= 1'b0;
        end
    end

    assign out_s       = rnd_q;
    assign bus.M       = m_q;
    assign bus.EXP_INC = inc_q;
`else
    assign out_s = pipe[STAGES-1];
`endif

    assign bus.OUT_VALID = out_s.valid;
    assign bus.R         = out_s.prod[PW-1:W-1];
    assign bus.STICKY    = |out_s.prod[W-2:0];
    assign bus.OUT_TAG   = out_s.tag[TAG_W-1:0];

    // Pad bits of the wide payload carry nothing in narrow builds.
    assign unused_pad = ^out_s;

endmodule

// File: tb/tb_mant_mult_pipe.sv
// Self-checking bench for mant_mult_pipe (W=24, STAGES=2, TAG_W=4).
// Covers both builds: with and without MANT_MULT_ROUND_EN.
module tb_mant_mult_pipe;

    localparam int W  = 24;
    localparam int ST = 2;
    localparam int TW = 4;
`ifdef MANT_MULT_ROUND_EN
    localparam int LAT = ST + 1;
`else
    localparam int LAT = ST;
`endif

    logic clk;
    logic rst;

    mant_mult_if #(.W(W), .TAG_W(TW)) bus ();

    mant_mult_pipe #(.W(W), .STAGES(ST), .TAG_W(TW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_drained = 0;
    int n_sent = 0;
    logic [63:0] exp_q [$];

    function automatic logic [63:0] pk(logic [24:0] r, logic s,
                                       logic [3:0] t, logic [23:0] m,
                                       logic inc);
`ifdef MANT_MULT_ROUND_EN
        return {9'd0, r, s, t, m, inc};
`else
        return {9'd0, r, s, t, 24'd0, 1'b0};
`endif
    endfunction

    function automatic logic [63:0] got();
`ifdef MANT_MULT_ROUND_EN
        return pk(bus.R, bus.STICKY, bus.OUT_TAG, bus.M, bus.EXP_INC);
`else
        return pk(bus.R, bus.STICKY, bus.OUT_TAG, 24'd0, 1'b0);
`endif
    endfunction

    // Reference: exact product, then slice/sticky and RNE by arithmetic.
    function automatic logic [63:0] model(logic [23:0] a, logic [23:0] b,
                                          logic [3:0] t);
        longint unsigned pa, p, mant, rem, half;
        int sh;
        logic inc;
        pa = longint'(a);
        p  = pa * longint'(b);
        sh  = (p >= (64'd1 << 47)) ? 24 : 23;
        inc = (sh == 24);
        mant = p >> sh;
        rem  = p - (mant << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0]))
            mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            inc  = 1'b1;
        end
        return pk(25'(p >> 23), (p % (64'd1 << 23)) != 0, t,
                  24'(mant), inc);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: account for handshakes at this sample point, then advance.
    task automatic tick();
        logic [63:0] e;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.OUT_VALID === 1'b1 && bus.OUT_READY) begin
                check("drain_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", got(), e);
                    n_drained++;
                end
            end
            if (bus.IN_VALID && bus.IN_READY === 1'b1) begin
                exp_q.push_back(model(bus.A, bus.B, bus.IN_TAG));
                n_sent++;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_op();
        bus.A = 24'($urandom);
        bus.B = 24'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            bus.A[23] = 1'b1;
            bus.B[23] = 1'b1;
        end
        bus.IN_TAG = 4'($urandom);
    endtask

    // Send one op alone, return cycles until OUT_VALID rises.
    task automatic send_one(logic [23:0] a, logic [23:0] b,
                            logic [3:0] t, output int lat);
        bus.A = a;
        bus.B = b;
        bus.IN_TAG = t;
        bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        lat = 1;
        while (bus.OUT_VALID !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(LAT));
    endtask

    int lat;
    int base_sent;
    int base_drained;
    int acc;
    int cyc;
    int i;
    logic stall;

    initial begin
        rst = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.OUT_READY = 1'b1;
        rand_op();
        @(negedge clk);

        // Reset held with IN_VALID high: nothing gets through.
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
            check("rst_in_ready", 64'(bus.IN_READY), 64'd1);
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("post_rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
            check("post_rst_in_ready", 64'(bus.IN_READY), 64'd1);
            tick();
            bus.IN_VALID = 1'b0;
        end
        for (int k = 0; k < LAT + 1; k++) tick();

        // Unity.
        send_one(24'h800000, 24'h800000, 4'd5, lat);
        check("unity", got(), pk(25'h0800000, 1'b0, 4'd5,
                                 24'h800000, 1'b0));
        tick();

        // Maximum operands.
        send_one(24'hFFFFFF, 24'hFFFFFF, 4'd9, lat);
        check("max", got(), pk(25'h1FFFFFC, 1'b1, 4'd9,
                               24'hFFFFFE, 1'b1));
        tick();

        // Back-to-back stream of 100.
        base_sent = n_sent;
        base_drained = n_drained;
        for (int k = 0; k < 100; k++) begin
            rand_op();
            bus.IN_VALID = 1'b1;
            tick();
        end
        bus.IN_VALID = 1'b0;
        for (int k = 0; k < LAT + 2; k++) tick();
        check("b2b_sent", 64'(n_sent - base_sent), 64'd100);
        check("b2b_drained", 64'(n_drained - base_drained), 64'd100);

        // Backpressure mid-stream.
        base_sent = n_sent;
        base_drained = n_drained;
        i = 0;
        cyc = 0;
        rand_op();
        while (i < 20 && cyc < 200) begin
            bus.IN_VALID = 1'b1;
            stall = (cyc >= 8 && cyc < 13);
            bus.OUT_READY = !stall;
            #1;
            if (stall) begin
                check("bp_in_ready", 64'(bus.IN_READY), 64'd0);
                check("bp_out_valid", 64'(bus.OUT_VALID), 64'd1);
                if (exp_q.size() != 0)
                    check("bp_frozen", got(), exp_q[0]);
            end
            acc = (bus.IN_READY === 1'b1) ? 1 : 0;
            tick();
            if (acc == 1) begin
                i++;
                rand_op();
            end
            cyc++;
        end
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;
        for (int k = 0; k < LAT + 2; k++) tick();
        check("bp_sent", 64'(n_sent - base_sent), 64'd20);
        check("bp_drained", 64'(n_drained - base_drained), 64'd20);

        // Reset with two operations in flight.
        rand_op();
        bus.IN_VALID = 1'b1;
        tick();
        rand_op();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.IN_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("midrst_out_valid", 64'(bus.OUT_VALID), 64'd0);
            tick();
        end
        send_one(24'hC00000, 24'hA00001, 4'd3, lat);
        check("after_rst", got(), model(24'hC00000, 24'hA00001, 4'd3));
        tick();

        for (int k = 0; k < LAT + 2; k++) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
